infer_scheduler: RTL and testbench
==================================

INFER_SCHEDULER -- requirements
Module: infer_scheduler

Interface
REQ-001 Parameter: D_W, 128, input state width (32 cells x 4 bits), passed unchanged to net_d.
REQ-002 Parameter: TO_CYCLES, 4096, watchdog limit in cycles of RUN without net_valid.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: req0_valid / req1_valid  input  1  requester has a job pending.
REQ-006 Port: req0_d / req1_d  input  D_W  requester input state, valid with reqN_valid.
REQ-007 Port: req0_ready / req1_ready  output  1  job accepted this cycle (combinational, IDLE only).
REQ-008 Port: net_load  output  1  load/start strobe to the network, level-held during a job.
REQ-009 Port: net_d  output  D_W  registered state driven to the network.
REQ-010 Port: net_valid  input  1  network result valid.
REQ-011 Port: net_q  input  4  network result class.
REQ-012 Port: rsp_valid  output  1  response available.
REQ-013 Port: rsp_ready  input  1  consumer accepts response.
REQ-014 Port: rsp_id  output  1  requester index that owns the response.
REQ-015 Port: rsp_q  output  4  captured result class.
REQ-016 Port: rsp_timeout  output  1  response produced by watchdog, not the network.
REQ-017 Port: busy  output  1  high in any state other than IDLE.
REQ-018 Port: job_cnt  output  16  completed responses, wraps 0xFFFF->0x0000.

Function
REQ-019 FSM states IDLE, RUN, RESP; IDLE->RUN on accept, RUN->RESP on net_valid (or timeout), RESP->IDLE on rsp_valid&rsp_ready.
REQ-020 IDLE accepts a job only when net_valid==0; exactly one reqN_ready high per accept cycle.
REQ-021 Arbitration round-robin: both valid -> grant the requester not granted last; after reset req0 has priority.
REQ-022 Single valid requester is granted regardless of round-robin pointer; pointer updates only on accept.
REQ-023 On accept, net_d <= granted reqN_d and grant id stored; net_load rises the following cycle (entry into RUN).
REQ-024 net_load==1 exactly while in RUN; net_d stable throughout RUN.
REQ-025 In RUN, net_valid==1 captures net_q into rsp_q, rsp_timeout<=0, next state RESP; net_load low in RESP.
REQ-026 RESP holds rsp_valid, rsp_id, rsp_q, rsp_timeout stable until rsp_ready; job_cnt increments on that handshake.
REQ-027 net_valid outside RUN is ignored; reqN_valid outside IDLE leaves reqN_ready low.
REQ-028 Minimum one cycle with net_load low between consecutive jobs (guaranteed by RESP).

Reset
REQ-029 rst_n==0 at a clock edge: state IDLE, net_load 0, net_d 0, rsp_valid 0, rsp_id 0, rsp_q 0, rsp_timeout 0, job_cnt 0, RR pointer favours req0, watchdog 0.
REQ-030 Reset mid-RUN or mid-RESP aborts the job with no response and no job_cnt increment.

Configuration
REQ-031 Macro INFER_TIMEOUT_EN defined: a watchdog counts RUN cycles; reaching TO_CYCLES without net_valid forces RESP with rsp_q=4'hF, rsp_timeout=1.
REQ-032 INFER_TIMEOUT_EN undefined: no watchdog logic, RUN waits indefinitely, rsp_timeout tied 0.
REQ-033 With macro, net_valid and watchdog expiry in the same cycle: net_valid wins, rsp_timeout=0.

Verification
REQ-034 Reset, req0_valid=1 d=128'h82a54907b1630900184e800098f -> req0_ready 1 cycle, net_load high next cycle, net_d equals d.
REQ-035 Model asserts net_valid with net_q=4'h5 after 300 cycles -> rsp_valid=1, rsp_id=0, rsp_q=4'h5; rsp_ready -> job_cnt=1, IDLE.
REQ-036 req0 and req1 both continuously valid for 4 jobs -> grant order 0,1,0,1; net_load low >=1 cycle between jobs.
REQ-037 Hold rsp_ready=0 for 20 cycles -> rsp fields stable, no new accept, busy=1 throughout.
REQ-038 INFER_TIMEOUT_EN, TO_CYCLES=16, net_valid never -> RESP after 16 RUN cycles, rsp_q=4'hF, rsp_timeout=1.
REQ-039 rst_n low for one cycle mid-RUN -> net_load 0, rsp_valid 0, job_cnt 0 next cycle.

Source files
------------

// File: rtl/infer_scheduler_if.sv
// Bundle of requester, network and response handshakes for infer_scheduler.
// slave = scheduler side, master = environment (requesters, network, consumer).
interface infer_scheduler_if #(
    parameter int D_W = 128
);
    logic           req0_valid;
    logic [D_W-1:0] req0_d;
    logic           req0_ready;
    logic           req1_valid;
    logic [D_W-1:0] req1_d;
    logic           req1_ready;

    logic           net_load;
    logic [D_W-1:0] net_d;
    logic           net_valid;
    logic [3:0]     net_q;

    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [3:0]     rsp_q;
    logic           rsp_timeout;

    modport slave (
        input  req0_valid, req0_d, req1_valid, req1_d, net_valid, net_q, rsp_ready,
        output req0_ready, req1_ready, net_load, net_d, rsp_valid, rsp_id, rsp_q,
               rsp_timeout
    );

    modport master (
        output req0_valid, req0_d, req1_valid, req1_d, net_valid, net_q, rsp_ready,
        input  req0_ready, req1_ready, net_load, net_d, rsp_valid, rsp_id, rsp_q,
               rsp_timeout
    );
endinterface

// File: rtl/infer_scheduler.sv
// Two-requester round-robin scheduler feeding one inference network.
// Optional RUN watchdog enabled by defining INFER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a request; accepts only while net_valid is low
// RUN   | net_load held, waiting for net_valid (or watchdog expiry)
// RESP  | response presented until rsp_ready
module infer_scheduler #(
    parameter int D_W       = 128,
    parameter int TO_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    infer_scheduler_if.slave    bus,
    output logic                busy,
    output logic [15:0]         job_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    if (TO_CYCLES < 1) begin : g_to_check
        $error("infer_scheduler: TO_CYCLES must be at least 1");
    end

    state_t         state_q, state_d;
    logic           net_load_q, net_load_d;
    logic [D_W-1:0] net_d_q, net_d_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_id_q, rsp_id_d;
    logic [3:0]     rsp_class_q, rsp_class_d;
    logic           rr_prio1_q, rr_prio1_d;
    logic [15:0]    job_cnt_q, job_cnt_d;

    logic           accept;
    logic           grant1;

`ifdef INFER_TIMEOUT_EN
    localparam int WD_W = $clog2(TO_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            rsp_timeout_q, rsp_timeout_d;
    logic            wd_expired;

    assign wd_expired      = (wd_q == '0);
    assign bus.rsp_timeout = rsp_timeout_q;
`else
    assign bus.rsp_timeout = 1'b0;
`endif

    // rr_prio1_q set means req1 wins a tie; a lone requester always wins.
    assign accept = (state_q == IDLE) && !bus.net_valid && (bus.req0_valid || bus.req1_valid);
    assign grant1 = bus.req1_valid && (!bus.req0_valid || rr_prio1_q);

    assign bus.req0_ready = accept && !grant1;
    assign bus.req1_ready = accept && grant1;

    always_comb begin
        state_d     = state_q;
        net_load_d  = net_load_q;
        net_d_d     = net_d_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_class_d = rsp_class_q;
        rr_prio1_d  = rr_prio1_q;
        job_cnt_d   = job_cnt_q;
`ifdef INFER_TIMEOUT_EN
        wd_d          = wd_q;
        rsp_timeout_d = rsp_timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    net_d_d    = grant1 ? bus.req1_d : bus.req0_d;
                    rsp_id_d   = grant1;
                    rr_prio1_d = !grant1;
                    net_load_d = 1'b1;
                    state_d    = RUN;
`ifdef INFER_TIMEOUT_EN
                    wd_d = WD_W'(TO_CYCLES - 1);
`endif
                end
            end
            RUN: begin
                if (bus.net_valid) begin
                    rsp_class_d = bus.net_q;
                    rsp_valid_d = 1'b1;
                    net_load_d  = 1'b0;
                    state_d     = RESP;
`ifdef INFER_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
                end else if (wd_expired) begin
                    // Watchdog counts down from TO_CYCLES-1, so expiry lands on the last RUN cycle.
                    rsp_class_d   = 4'hF;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    net_load_d    = 1'b0;
                    state_d       = RESP;
                end else begin
                    wd_d = wd_q - 1'b1;
`endif
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    job_cnt_d   = job_cnt_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                net_load_d  = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            net_load_q  <= 1'b0;
            net_d_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_class_q <= 4'h0;
            rr_prio1_q  <= 1'b0;
            job_cnt_q   <= 16'h0000;
`ifdef INFER_TIMEOUT_EN
            wd_q          <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            net_load_q  <= net_load_d;
            net_d_q     <= net_d_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_class_q <= rsp_class_d;
            rr_prio1_q  <= rr_prio1_d;
            job_cnt_q   <= job_cnt_d;
`ifdef INFER_TIMEOUT_EN
            wd_q          <= wd_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

    assign bus.net_load  = net_load_q;
    assign bus.net_d     = net_d_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_q     = rsp_class_q;
    assign busy          = (state_q != IDLE);
    assign job_cnt       = job_cnt_q;

endmodule

// File: tb/tb_infer_scheduler.sv
// Directed bench for infer_scheduler: single job, arbitration, backpressure,
// mid-job reset and RUN timeout behaviour (watchdog checks when INFER_TIMEOUT_EN is set).
module tb_infer_scheduler;

    localparam int D_W = 128;
    localparam int TO  = 16;

    logic        clk;
    logic        rst_n;
    logic        busy;
    logic [15:0] job_cnt;

    int checks   = 0;
    int failures = 0;

    infer_scheduler_if #(.D_W(D_W)) bus ();

    infer_scheduler #(.D_W(D_W), .TO_CYCLES(TO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .busy    (busy),
        .job_cnt (job_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [127:0] d0, da, db;
    logic         exp_id;
    int           cnt;
    int           hold_bad;

    initial begin
        d0 = 128'h82a54907b1630900184e800098f;
        da = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
        db = 128'hfedc_ba98_7654_3210_8899_aabb_ccdd_eeff;

        bus.req0_valid = 0; bus.req0_d = '0;
        bus.req1_valid = 0; bus.req1_d = '0;
        bus.net_valid  = 0; bus.net_q  = 4'h0;
        bus.rsp_ready  = 0;
        rst_n = 0;
        @(negedge clk);
        tick();
        tick();

        chk("rst_busy",     busy, 0);
        chk("rst_net_load", bus.net_load, 0);
        chk("rst_net_d",    bus.net_d, 0);
        chk("rst_rsp_valid",bus.rsp_valid, 0);
        chk("rst_rsp_id",   bus.rsp_id, 0);
        chk("rst_rsp_q",    bus.rsp_q, 0);
        chk("rst_timeout",  bus.rsp_timeout, 0);
        chk("rst_job_cnt",  job_cnt, 0);
        rst_n = 1;
        tick();

        // single job from req0
        bus.req0_valid = 1; bus.req0_d = d0;
        #1;
        chk("j0_req0_ready", bus.req0_ready, 1);
        chk("j0_req1_ready", bus.req1_ready, 0);
        chk("j0_load_not_yet", bus.net_load, 0);
        tick();
        bus.req0_valid = 0; bus.req0_d = '0;
        chk("j0_net_load", bus.net_load, 1);
        chk("j0_net_d", bus.net_d, d0);
        chk("j0_busy", busy, 1);
        bus.req1_valid = 1; bus.req1_d = db;
        #1;
        chk("j0_run_no_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
        bus.req1_valid = 0;
        hold_bad = 0;
        for (int i = 0; i < 299; i++) begin
            tick();
            if (bus.net_load !== 1'b1 || bus.net_d !== d0 || bus.rsp_valid !== 1'b0) hold_bad++;
        end
        chk("j0_run_stable", hold_bad, 0);
        bus.net_valid = 1; bus.net_q = 4'h5;
        tick();
        bus.net_valid = 0; bus.net_q = 4'h0;
        chk("j0_rsp_valid", bus.rsp_valid, 1);
        chk("j0_rsp_id", bus.rsp_id, 0);
        chk("j0_rsp_q", bus.rsp_q, 4'h5);
        chk("j0_rsp_timeout", bus.rsp_timeout, 0);
        chk("j0_resp_load_low", bus.net_load, 0);
        bus.rsp_ready = 1;
        tick();
        bus.rsp_ready = 0;
        chk("j0_job_cnt", job_cnt, 1);
        chk("j0_idle", busy, 0);
        chk("j0_rsp_drop", bus.rsp_valid, 0);

        // net_valid high in IDLE blocks acceptance
        bus.req0_valid = 1; bus.req0_d = da; bus.net_valid = 1;
        #1;
        chk("nv_idle_block", {bus.req0_ready, bus.req1_ready}, 2'b00);
        tick();
        chk("nv_idle_stays", busy, 0);
        bus.net_valid = 0;

        // pointer favours req1 now, but a lone req0 is still granted
        #1;
        chk("lone_req0_ready", {bus.req1_ready, bus.req0_ready}, 2'b01);
        tick();
        bus.req0_valid = 0;
        chk("lone_net_d", bus.net_d, da);
        repeat (3) tick();

        // one-cycle reset in the middle of RUN
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("mid_rst_load", bus.net_load, 0);
        chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
        chk("mid_rst_job_cnt", job_cnt, 0);
        chk("mid_rst_busy", busy, 0);
        bus.net_valid = 1; bus.net_q = 4'h7;
        tick();
        bus.net_valid = 0;
        chk("nv_ignored_idle", {busy, bus.rsp_valid}, 2'b00);

        // both requesters continuously valid: grants alternate 0,1,0,1
        bus.req0_valid = 1; bus.req0_d = da;
        bus.req1_valid = 1; bus.req1_d = db;
        for (int j = 0; j < 4; j++) begin
            exp_id = j[0];
            #1;
            chk("rr_ready", {bus.req1_ready, bus.req0_ready}, exp_id ? 2'b10 : 2'b01);
            tick();
            chk("rr_net_load", bus.net_load, 1);
            chk("rr_net_d", bus.net_d, exp_id ? db : da);
            repeat (3) tick();
            bus.net_valid = 1; bus.net_q = 4'(j + 3);
            tick();
            bus.net_valid = 0;
            chk("rr_rsp_id", bus.rsp_id, exp_id);
            chk("rr_rsp_q", bus.rsp_q, 4'(j + 3));
            chk("rr_gap_load_low", bus.net_load, 0);
            if (j == 1) begin
                for (int k = 0; k < 20; k++) begin
                    tick();
                    chk("hold_resp",
                        {bus.rsp_valid, bus.rsp_id, bus.rsp_q, busy, bus.req0_ready,
                         bus.req1_ready, bus.net_load},
                        {1'b1, 1'b1, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0});
                end
            end
            bus.rsp_ready = 1;
            tick();
            bus.rsp_ready = 0;
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        chk("rr_job_cnt", job_cnt, 4);

`ifdef INFER_TIMEOUT_EN
        // network never answers: watchdog closes the job after TO RUN cycles
        bus.req0_valid = 1; bus.req0_d = da;
        tick();
        bus.req0_valid = 0;
        cnt = 0;
        while (bus.net_load === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        chk("to_run_cycles", cnt, TO);
        chk("to_rsp_valid", bus.rsp_valid, 1);
        chk("to_rsp_q", bus.rsp_q, 4'hF);
        chk("to_rsp_timeout", bus.rsp_timeout, 1);
        bus.rsp_ready = 1;
        tick();
        bus.rsp_ready = 0;
        chk("to_job_cnt", job_cnt, 5);

        // net_valid on the expiry cycle wins
        bus.req1_valid = 1; bus.req1_d = db;
        tick();
        bus.req1_valid = 0;
        repeat (TO - 1) tick();
        chk("tie_still_run", bus.net_load, 1);
        bus.net_valid = 1; bus.net_q = 4'h2;
        tick();
        bus.net_valid = 0;
        chk("tie_rsp_q", bus.rsp_q, 4'h2);
        chk("tie_rsp_timeout", bus.rsp_timeout, 0);
        bus.rsp_ready = 1;
        tick();
        bus.rsp_ready = 0;
`else
        // without the watchdog RUN waits indefinitely
        bus.req0_valid = 1; bus.req0_d = da;
        tick();
        bus.req0_valid = 0;
        repeat (3 * TO) tick();
        chk("nowd_still_run", {bus.net_load, bus.rsp_valid, busy}, 3'b101);
        chk("nowd_timeout_low", bus.rsp_timeout, 0);
        bus.net_valid = 1; bus.net_q = 4'h9;
        tick();
        bus.net_valid = 0;
        chk("nowd_rsp_q", bus.rsp_q, 4'h9);
        bus.rsp_ready = 1;
        tick();
        bus.rsp_ready = 0;
        chk("nowd_job_cnt", job_cnt, 5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
